ghost_mover: RTL and testbench

//  Parametrised grid mover for one ghost. It replaces the fixed 18x5 per-ghost movers.

---
 rtl/ghost_mover.sv | 197 +++++++++++++++++++
 tb/tb_ghost_mover.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_mover.sv
// Grid mover for one ghost: position, step-rate counter, buffered turn, optional edge wrap
// and a home/penalty hold sequence. Position feeds the renderer and collision logic.
//
// state  | meaning
// S_PARK | scene not in play: parked on the home cell, counters cleared
// S_RUN  | moving one cell per step, honouring the buffered turn when legal
// S_HOME | eaten: held on the home cell for HOME_TICKS steps before moving again
module ghost_mover #(
  parameter int         MAP_W       = 18,
  parameter int         MAP_H       = 5,
  parameter int         HOME_X      = 10,
  parameter int         HOME_Y      = 0,
  parameter logic [1:0] START_DIR   = 2'b10,
  parameter int         STEP_CYCLES = 33554432,
  parameter int         HOME_TICKS  = 4,
  parameter bit         WRAP_EN     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             scene,
  input  logic [MAP_W*MAP_H-1:0] map,
  input  logic [1:0]             dir_req,
  input  logic                   dir_valid,
  input  logic                   go_home,
  output logic [4:0]             pos_x,
  output logic [4:0]             pos_y,
  output logic [1:0]             cur_dir,
  output logic                   moved,
  output logic                   blocked,
  output logic                   at_home
);

  localparam int N  = MAP_W * MAP_H;
  localparam int IW = $clog2(N) + 1;
  localparam int CW = $clog2(STEP_CYCLES);
  localparam int HW = $clog2(HOME_TICKS + 1);

  localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [HW-1:0] HOME_LAST  = HW'(HOME_TICKS - 1);
  localparam logic [4:0]    HX         = 5'(HOME_X);
  localparam logic [4:0]    HY         = 5'(HOME_Y);
  localparam logic [4:0]    XMAX       = 5'(MAP_W - 1);
  localparam logic [4:0]    YMAX       = 5'(MAP_H - 1);
  localparam logic [1:0]    SCENE_PLAY = 2'b01;

  typedef enum logic [1:0] {
    S_PARK = 2'd0,
    S_RUN  = 2'd1,
    S_HOME = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [4:0]    pos_x_nx, pos_y_nx;
  logic [1:0]    cur_dir_nx;
  logic          pend_valid, pend_valid_nx;
  logic [1:0]    pend_dir, pend_dir_nx;
  logic [CW-1:0] step_cnt, step_nx;
  logic [HW-1:0] home_cnt, home_nx;
  logic          moved_nx, blocked_nx;
  logic          step_wrap, tick;
  logic [4:0]    pend_x, pend_y, cur_x, cur_y;
  logic          pend_ok, cur_ok;

  // Neighbour of (x,y) in direction d; returns 1 when that cell is reachable and free.
  function automatic logic probe(input logic [4:0] x, input logic [4:0] y, input logic [1:0] d,
                                 input logic [N-1:0] m, output logic [4:0] nx,
                                 output logic [4:0] ny);
    logic          ok;
    logic [IW-1:0] idx;
    logic [N-1:0]  one_hot;
    nx = x;
    ny = y;
    ok = 1'b1;
    case (d)
      2'b00: if (y == 5'd0) begin ny = YMAX; ok = WRAP_EN; end else ny = y - 5'd1;
      2'b01: if (y == YMAX) begin ny = 5'd0; ok = WRAP_EN; end else ny = y + 5'd1;
      2'b10: if (x == 5'd0) begin nx = XMAX; ok = WRAP_EN; end else nx = x - 5'd1;
      2'b11: if (x == XMAX) begin nx = 5'd0; ok = WRAP_EN; end else nx = x + 5'd1;
      default: ok = 1'b0;
    endcase
    idx     = IW'(nx) + IW'(ny) * IW'(MAP_W);
    one_hot = {{(N-1){1'b0}}, 1'b1} << idx;
    return ok & ~(|(m & one_hot));
  endfunction

  assign step_wrap = (step_cnt == STEP_LAST);
  assign tick      = (state == S_RUN) && step_wrap;
  assign at_home   = (state == S_HOME);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PARK;
      pos_x      <= HX;
      pos_y      <= HY;
      cur_dir    <= START_DIR;
      pend_valid <= 1'b0;
      pend_dir   <= 2'b00;
      step_cnt   <= '0;
      home_cnt   <= '0;
      moved      <= 1'b0;
      blocked    <= 1'b0;
    end else begin
      state      <= state_nx;
      pos_x      <= pos_x_nx;
      pos_y      <= pos_y_nx;
      cur_dir    <= cur_dir_nx;
      pend_valid <= pend_valid_nx;
      pend_dir   <= pend_dir_nx;
      step_cnt   <= step_nx;
      home_cnt   <= home_nx;
      moved      <= moved_nx;
      blocked    <= blocked_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pos_x_nx      = pos_x;
    pos_y_nx      = pos_y;
    cur_dir_nx    = cur_dir;
    pend_valid_nx = pend_valid;
    pend_dir_nx   = pend_dir;
    step_nx       = step_wrap ? '0 : step_cnt + 1'b1;
    home_nx       = home_cnt;
    moved_nx      = 1'b0;
    blocked_nx    = 1'b0;
    pend_x        = 5'd0;
    pend_y        = 5'd0;
    cur_x         = 5'd0;
    cur_y         = 5'd0;
    pend_ok       = probe(pos_x, pos_y, pend_dir, map, pend_x, pend_y);
    cur_ok        = probe(pos_x, pos_y, cur_dir, map, cur_x, cur_y);

    if (scene != SCENE_PLAY) begin
      state_nx      = S_PARK;
      pos_x_nx      = HX;
      pos_y_nx      = HY;
      cur_dir_nx    = START_DIR;
      pend_valid_nx = 1'b0;
      step_nx       = '0;
      home_nx       = '0;
    end else begin
      case (state)
        S_PARK: begin
          state_nx = S_RUN;
          step_nx  = '0;
        end
        S_RUN: begin
          if (go_home) begin
            state_nx      = S_HOME;
            pos_x_nx      = HX;
            pos_y_nx      = HY;
            cur_dir_nx    = START_DIR;
            pend_valid_nx = 1'b0;
            home_nx       = '0;
          end else begin
            if (tick) begin
              if (pend_valid && pend_ok) begin
                pos_x_nx      = pend_x;
                pos_y_nx      = pend_y;
                cur_dir_nx    = pend_dir;
                pend_valid_nx = 1'b0;
                moved_nx      = 1'b1;
              end else if (cur_ok) begin
                pos_x_nx = cur_x;
                pos_y_nx = cur_y;
                moved_nx = 1'b1;
              end else begin
                blocked_nx = 1'b1;
              end
            end
            // A turn strobed on the tick edge is stored after the move and wins over its clear.
            if (dir_valid) begin
              pend_valid_nx = 1'b1;
              pend_dir_nx   = dir_req;
            end
          end
        end
        S_HOME: begin
          if (go_home) begin
            home_nx = '0;
          end else if (step_wrap) begin
            if (home_cnt == HOME_LAST) begin
              state_nx = S_RUN;
              step_nx  = '0;
              home_nx  = '0;
            end else begin
              home_nx = home_cnt + 1'b1;
            end
          end
        end
        default: state_nx = S_PARK;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_mover.sv
// Bench for ghost_mover: a no-wrap and a wrap instance share stimulus and are checked
// every cycle against a cell-level reference model, plus fixed expectations per scenario.
module tb_ghost_mover;
  localparam int W  = 18;
  localparam int H  = 5;
  localparam int N  = W * H;
  localparam int SC = 4;
  localparam int HT = 2;
  localparam logic [14:0] RST_VEC = {5'd10, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   scene;
  logic [N-1:0] map;
  logic [1:0]   dir_req;
  logic         dir_valid;
  logic         go_home;
  logic [4:0]   px0, py0, px1, py1;
  logic [1:0]   cd0, cd1;
  logic         mv0, bl0, ah0, mv1, bl1, ah1;

  int n_cmp  = 0;
  int n_fail = 0;

  // model: mode 0 parked, 1 roaming, 2 held at home
  int m_mode[2], m_x[2], m_y[2], m_dir[2], m_pv[2], m_pd[2], m_cnt[2], m_hc[2];
  bit m_mv[2], m_bl[2];

  ghost_mover #(.MAP_W(W), .MAP_H(H), .HOME_X(10), .HOME_Y(0), .START_DIR(2'b10),
                .STEP_CYCLES(SC), .HOME_TICKS(HT), .WRAP_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .scene(scene), .map(map), .dir_req(dir_req),
    .dir_valid(dir_valid), .go_home(go_home), .pos_x(px0), .pos_y(py0), .cur_dir(cd0),
    .moved(mv0), .blocked(bl0), .at_home(ah0));

  ghost_mover #(.MAP_W(W), .MAP_H(H), .HOME_X(10), .HOME_Y(0), .START_DIR(2'b10),
                .STEP_CYCLES(SC), .HOME_TICKS(HT), .WRAP_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .scene(scene), .map(map), .dir_req(dir_req),
    .dir_valid(dir_valid), .go_home(go_home), .pos_x(px1), .pos_y(py1), .cur_dir(cd1),
    .moved(mv1), .blocked(bl1), .at_home(ah1));

  function automatic logic [14:0] dut_vec(int w);
    return (w == 0) ? {px0, py0, cd0, mv0, bl0, ah0} : {px1, py1, cd1, mv1, bl1, ah1};
  endfunction

  function automatic logic [14:0] mdl_vec(int w);
    return {5'(m_x[w]), 5'(m_y[w]), 2'(m_dir[w]), m_mv[w], m_bl[w], (m_mode[w] == 2)};
  endfunction

  function automatic bit legal(int w, int d, output int nx, output int ny);
    nx = m_x[w] + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
    ny = m_y[w] + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
    if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
      if (w == 0) return 1'b0;
      nx = (nx + W) % W;
      ny = (ny + H) % H;
    end
    return map[nx + ny * W] == 1'b0;
  endfunction

  task automatic model_home(int w, int mode);
    m_mode[w] = mode; m_x[w] = 10; m_y[w] = 0; m_dir[w] = 2; m_pv[w] = 0; m_hc[w] = 0;
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      model_home(w, 0);
      m_pd[w] = 0; m_cnt[w] = 0; m_mv[w] = 0; m_bl[w] = 0;
    end
  endtask

  task automatic model_edge();
    int nx, ny;
    for (int w = 0; w < 2; w++) begin
      m_mv[w] = 0;
      m_bl[w] = 0;
      if (scene != 2'b01) begin
        model_home(w, 0);
        m_cnt[w] = 0;
      end else if (m_mode[w] == 0) begin
        m_mode[w] = 1;
      end else if (m_mode[w] == 1) begin
        if (go_home) begin
          model_home(w, 2);
          m_cnt[w] = (m_cnt[w] + 1) % SC;
        end else begin
          if (m_cnt[w] == SC - 1) begin
            if (m_pv[w] != 0 && legal(w, m_pd[w], nx, ny)) begin
              m_x[w] = nx; m_y[w] = ny; m_dir[w] = m_pd[w]; m_pv[w] = 0; m_mv[w] = 1;
            end else if (legal(w, m_dir[w], nx, ny)) begin
              m_x[w] = nx; m_y[w] = ny; m_mv[w] = 1;
            end else begin
              m_bl[w] = 1;
            end
          end
          m_cnt[w] = (m_cnt[w] + 1) % SC;
          if (dir_valid) begin
            m_pv[w] = 1;
            m_pd[w] = dir_req;
          end
        end
      end else begin
        if (go_home) begin
          m_hc[w]  = 0;
          m_cnt[w] = (m_cnt[w] + 1) % SC;
        end else if (m_cnt[w] == SC - 1) begin
          m_cnt[w] = 0;
          if (m_hc[w] == HT - 1) m_mode[w] = 1;
          else m_hc[w]++;
        end else begin
          m_cnt[w]++;
        end
      end
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; scene = 2'b00; dir_valid = 1'b0; dir_req = 2'b00; go_home = 1'b0;
    clk_step();
    clk_step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    map = '0;
    do_reset();
    n_cmp++;
    if ({dut_vec(0), dut_vec(1)} !== {RST_VEC, RST_VEC}) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%h want %h", dut_vec(0), dut_vec(1), RST_VEC);
    end
  endtask

  task automatic test_basic();
    map = '0;
    do_reset();
    scene = 2'b01;
    for (int e = 1; e <= 9; e++) begin
      clk_step();
      for (int w = 0; w < 2; w++) begin
        n_cmp++;
        if (dut_vec(w) !== mdl_vec(w)) begin
          n_fail++;
          $display("FAIL basic_model w%0d e%0d: got %h want %h", w, e, dut_vec(w), mdl_vec(w));
        end
      end
      if (e == 5 || e == 6 || e == 9) begin
        n_cmp++;
        if ({px0, py0, mv0, px1, py1, mv1} !== ((e == 9) ? {5'd8, 5'd0, 1'b1, 5'd8, 5'd0, 1'b1} :
            (e == 5) ? {5'd9, 5'd0, 1'b1, 5'd9, 5'd0, 1'b1} : {5'd9, 5'd0, 1'b0, 5'd9, 5'd0, 1'b0})) begin
          n_fail++;
          $display("FAIL basic_step e%0d: got (%0d,%0d) moved=%b", e, px0, py0, mv0);
        end
      end
    end
  endtask

  task automatic test_pending();
    map = '0;
    map[9 + 1 * W] = 1'b1;
    do_reset();
    scene = 2'b01;
    for (int e = 1; e <= 13; e++) begin
      dir_valid = (e == 6);
      dir_req   = 2'b01;
      clk_step();
      for (int w = 0; w < 2; w++) begin
        n_cmp++;
        if (dut_vec(w) !== mdl_vec(w)) begin
          n_fail++;
          $display("FAIL pend_model w%0d e%0d: got %h want %h", w, e, dut_vec(w), mdl_vec(w));
        end
      end
      if (e == 9 || e == 13) begin
        n_cmp++;
        if ({px0, py0, cd0} !== ((e == 9) ? {5'd8, 5'd0, 2'b10} : {5'd8, 5'd1, 2'b01})) begin
          n_fail++;
          $display("FAIL pend_turn e%0d: got (%0d,%0d) dir=%b", e, px0, py0, cd0);
        end
      end
    end
    dir_valid = 1'b0;
  endtask

  task automatic test_edge();
    for (int pass = 0; pass < 2; pass++) begin
      map = '0;
      if (pass == 1) map[17 + 2 * W] = 1'b1;
      do_reset();
      scene = 2'b01;
      for (int e = 1; e <= 54; e++) begin
        dir_valid = (e == 2) || (e == 10);
        dir_req   = (e <= 2) ? 2'b01 : 2'b10;
        clk_step();
        for (int w = 0; w < 2; w++) begin
          n_cmp++;
          if (dut_vec(w) !== mdl_vec(w)) begin
            n_fail++;
            $display("FAIL edge_model p%0d w%0d e%0d: got %h want %h", pass, w, e, dut_vec(w), mdl_vec(w));
          end
        end
        if (e == 49) begin
          n_cmp++;
          if ({px0, py0, px1, py1} !== {5'd0, 5'd2, 5'd0, 5'd2}) begin
            n_fail++;
            $display("FAIL edge_reach p%0d: got (%0d,%0d)/(%0d,%0d) want (0,2)", pass, px0, py0, px1, py1);
          end
        end
        if (e == 53) begin
          n_cmp++;
          if ({px0, py0, bl0, mv0} !== {5'd0, 5'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL edge_nowrap p%0d: got (%0d,%0d) bl=%b mv=%b", pass, px0, py0, bl0, mv0);
          end
          n_cmp++;
          if ({px1, py1, bl1, mv1} !== ((pass == 0) ? {5'd17, 5'd2, 1'b0, 1'b1} : {5'd0, 5'd2, 1'b1, 1'b0})) begin
            n_fail++;
            $display("FAIL edge_wrap p%0d: got (%0d,%0d) bl=%b mv=%b", pass, px1, py1, bl1, mv1);
          end
        end
      end
    end
    dir_valid = 1'b0;
  endtask

  task automatic test_home();
    map = '0;
    do_reset();
    scene = 2'b01;
    for (int e = 1; e <= 17; e++) begin
      go_home = (e == 7);
      clk_step();
      for (int w = 0; w < 2; w++) begin
        n_cmp++;
        if (dut_vec(w) !== mdl_vec(w)) begin
          n_fail++;
          $display("FAIL home_model w%0d e%0d: got %h want %h", w, e, dut_vec(w), mdl_vec(w));
        end
      end
      if (e == 7) begin
        n_cmp++;
        if ({px0, py0, ah0, px1, py1, ah1} !== {5'd10, 5'd0, 1'b1, 5'd10, 5'd0, 1'b1}) begin
          n_fail++;
          $display("FAIL home_enter: got (%0d,%0d) at_home=%b", px0, py0, ah0);
        end
      end
      if (e >= 8 && e <= 16) begin
        n_cmp++;
        if ((mv0 | mv1 | bl0 | bl1) !== 1'b0) begin
          n_fail++;
          $display("FAIL home_hold e%0d: moved=%b blocked=%b want 0", e, mv0, bl0);
        end
      end
      if (e == 12 || e == 13) begin
        n_cmp++;
        if (ah0 !== (e == 12)) begin
          n_fail++;
          $display("FAIL home_exit e%0d: at_home=%b want %b", e, ah0, (e == 12));
        end
      end
      if (e == 17) begin
        n_cmp++;
        if ({px0, py0, mv0} !== {5'd9, 5'd0, 1'b1}) begin
          n_fail++;
          $display("FAIL home_resume: got (%0d,%0d) moved=%b want (9,0) 1", px0, py0, mv0);
        end
      end
    end
    go_home = 1'b0;
  endtask

  task automatic test_scene();
    map = '0;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      scene = (e == 7) ? 2'b11 : 2'b01;
      clk_step();
      for (int w = 0; w < 2; w++) begin
        n_cmp++;
        if (dut_vec(w) !== mdl_vec(w)) begin
          n_fail++;
          $display("FAIL scene_model w%0d e%0d: got %h want %h", w, e, dut_vec(w), mdl_vec(w));
        end
      end
      if (e == 7 || e == 11 || e == 12) begin
        n_cmp++;
        if ({px0, py0, cd0, mv0} !== ((e == 12) ? {5'd9, 5'd0, 2'b10, 1'b1} : {5'd10, 5'd0, 2'b10, 1'b0})) begin
          n_fail++;
          $display("FAIL scene_park e%0d: got (%0d,%0d) dir=%b mv=%b", e, px0, py0, cd0, mv0);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    map = '0;
    do_reset();
    scene = 2'b01;
    for (int e = 1; e <= 7; e++) begin
      dir_valid = (e == 6);
      dir_req   = 2'b01;
      clk_step();
    end
    dir_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dut_vec(0), dut_vec(1)} !== {RST_VEC, RST_VEC}) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%h want %h", dut_vec(0), dut_vec(1), RST_VEC);
    end
    model_reset();
    clk_step();
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      clk_step();
      for (int w = 0; w < 2; w++) begin
        n_cmp++;
        if (dut_vec(w) !== mdl_vec(w)) begin
          n_fail++;
          $display("FAIL arst_model w%0d e%0d: got %h want %h", w, e, dut_vec(w), mdl_vec(w));
        end
      end
    end
    n_cmp++;
    if ({px0, py0, cd0} !== {5'd9, 5'd0, 2'b10}) begin
      n_fail++;
      $display("FAIL arst_pending_dropped: got (%0d,%0d) dir=%b want (9,0) 10", px0, py0, cd0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        for (int i = 0; i < N; i++) map[i] = ($urandom_range(0, 5) == 0);
      end
      scene     = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      dir_valid = ($urandom_range(0, 4) == 0);
      dir_req   = 2'($urandom);
      go_home   = ($urandom_range(0, 49) == 0) || (go_home && $urandom_range(0, 1) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      clk_step();
      for (int w = 0; w < 2; w++) begin
        n_cmp++;
        if (dut_vec(w) !== mdl_vec(w)) begin
          n_fail++;
          $display("FAIL rand_model w%0d c%0d: got %h want %h", w, c, dut_vec(w), mdl_vec(w));
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; scene = 2'b00; map = '0; dir_req = 2'b00; dir_valid = 1'b0; go_home = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_pending();
    test_edge();
    test_home();
    test_scene();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
